floor_scheduler: RTL and testbench

Request scheduler and car sequencer for the six-floor elevator on the DE1-SoC board. It latches hall and car calls from the synchronised switch inputs and picks the next floor with a SCAN (collective) policy. It steps the car position one floor at a time and times the door dwell, with an early-close input driven by the synchronised KEY[0]. It sits between the request front end and the HEX/LEDR display logic in the top level, and runs on the divided board clock.

---
 rtl/floor_scheduler_if.sv | 24 ++
 rtl/floor_scheduler.sv | 147 ++++++++++++++
 tb/tb_floor_scheduler.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/floor_scheduler_if.sv
// Request/status bundle between the elevator front end and floor_scheduler.
// master = request/display side, slave = scheduler.
interface floor_scheduler_if #(
  parameter int FLOORS = 6
);
  logic [FLOORS-1:0] call_req;
  logic              door_close;
  logic [2:0]        floor;
  logic              dir;
  logic              moving;
  logic              door_open;
  logic              arrive;
  logic [FLOORS-1:0] pending;

  modport master (
    output call_req, door_close,
    input  floor, dir, moving, door_open, arrive, pending
  );

  modport slave (
    input  call_req, door_close,
    output floor, dir, moving, door_open, arrive, pending
  );
endinterface

// File: rtl/floor_scheduler.sv
// SCAN (collective) request scheduler and car sequencer for the six-floor elevator:
// latches calls, steps the car one floor per TRAVEL_TICKS and times the door dwell.
module floor_scheduler #(
  parameter int FLOORS       = 6,
  parameter int TRAVEL_TICKS = 2,
  parameter int DOOR_TICKS   = 3
) (
  input  logic               clk,
  input  logic               reset,
  floor_scheduler_if.slave   bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MOVE = 2'd1;
  localparam logic [1:0] S_DOOR = 2'd2;

  localparam int TW = (TRAVEL_TICKS > 1) ? $clog2(TRAVEL_TICKS) : 1;
  localparam int DW = (DOOR_TICKS > 1) ? $clog2(DOOR_TICKS) : 1;

  logic [1:0]        state_q, state_d;
  logic [2:0]        floor_q, floor_d;
  logic              dir_q, dir_d;
  logic [FLOORS-1:0] pending_q, pending_d;
  logic [TW-1:0]     travel_q, travel_d;
  logic [DW-1:0]     door_q, door_d;
  logic              close_q, close_d;
  logic              arrive_q, arrive_d;

  logic [FLOORS-1:0] here, next_here, latch_mask, clear;
  logic [2:0]        next_floor;
  logic              up_req, dn_req, call_here;

  always_comb begin
    up_req = 1'b0;
    dn_req = 1'b0;
    for (int unsigned i = 0; i < FLOORS; i++) begin
      if (pending_q[i] && (i > 32'(floor_q))) up_req = 1'b1;
      if (pending_q[i] && (i < 32'(floor_q))) dn_req = 1'b1;
    end
  end

  assign here       = FLOORS'(1) << floor_q;
  assign next_floor = dir_q ? floor_q + 3'd1 : floor_q - 3'd1;
  assign next_here  = FLOORS'(1) << next_floor;
  assign call_here  = |(bus.call_req & here);
  // The car has left its floor while moving, so only IDLE/DOOR swallow a same-floor call.
  assign latch_mask = (state_q == S_MOVE) ? '0 : here;

  always_comb begin
    state_d  = state_q;
    floor_d  = floor_q;
    dir_d    = dir_q;
    travel_d = travel_q;
    door_d   = door_q;
    close_d  = close_q;
    arrive_d = 1'b0;
    clear    = '0;
    case (state_q)
      S_IDLE: begin
        if (call_here || |(pending_q & here)) begin
          state_d  = S_DOOR;
          arrive_d = 1'b1;
          clear    = here;
          door_d   = '0;
          close_d  = 1'b0;
        end else if (dir_q && up_req) begin
          state_d  = S_MOVE;
          travel_d = '0;
        end else if (!dir_q && dn_req) begin
          state_d  = S_MOVE;
          travel_d = '0;
        end else if (up_req) begin
          dir_d    = 1'b1;
          state_d  = S_MOVE;
          travel_d = '0;
        end else if (dn_req) begin
          dir_d    = 1'b0;
          state_d  = S_MOVE;
          travel_d = '0;
        end
      end
      S_MOVE: begin
        if (travel_q == TW'(TRAVEL_TICKS - 1)) begin
          travel_d = '0;
          floor_d  = next_floor;
          if (|(pending_q & next_here)) begin
            state_d  = S_DOOR;
            arrive_d = 1'b1;
            clear    = next_here;
            door_d   = '0;
            close_d  = 1'b0;
          end
        end else begin
          travel_d = travel_q + TW'(1);
        end
      end
      S_DOOR: begin
        // A same-floor call outranks both the dwell expiry and a pending early close.
        if (call_here) begin
          door_d  = '0;
          close_d = 1'b0;
        end else if (close_q || (door_q == DW'(DOOR_TICKS - 1))) begin
          state_d = S_IDLE;
          door_d  = '0;
          close_d = 1'b0;
        end else begin
          door_d  = door_q + DW'(1);
          close_d = bus.door_close;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    pending_d = (pending_q | (bus.call_req & ~latch_mask)) & ~clear;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      floor_q   <= '0;
      dir_q     <= 1'b1;
      pending_q <= '0;
      travel_q  <= '0;
      door_q    <= '0;
      close_q   <= 1'b0;
      arrive_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      floor_q   <= floor_d;
      dir_q     <= dir_d;
      pending_q <= pending_d;
      travel_q  <= travel_d;
      door_q    <= door_d;
      close_q   <= close_d;
      arrive_q  <= arrive_d;
    end
  end

  assign bus.floor     = floor_q;
  assign bus.dir       = dir_q;
  assign bus.moving    = (state_q == S_MOVE);
  assign bus.door_open = (state_q == S_DOOR);
  assign bus.arrive    = arrive_q;
  assign bus.pending   = pending_q;

endmodule

// File: tb/tb_floor_scheduler.sv
// Directed vector bench for floor_scheduler (FLOORS=6, TRAVEL_TICKS=2, DOOR_TICKS=3).
module tb_floor_scheduler;

  typedef struct {
    logic [5:0] call;
    logic       close;
    logic [2:0] floor;
    logic       dir;
    logic       moving;
    logic       door_open;
    logic       arrive;
    logic [5:0] pend;
  } vec_t;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  vec_t vecs[$];

  floor_scheduler_if #(.FLOORS(6)) ifc ();

  floor_scheduler #(
    .FLOORS(6),
    .TRAVEL_TICKS(2),
    .DOOR_TICKS(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(ifc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic addv(input logic [5:0] c, input logic cl, input logic [2:0] f,
                      input logic d, input logic m, input logic o, input logic a,
                      input logic [5:0] p);
    vec_t v;
    v.call = c; v.close = cl; v.floor = f; v.dir = d;
    v.moving = m; v.door_open = o; v.arrive = a; v.pend = p;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [2:0] f, input logic d,
                       input logic m, input logic o, input logic a, input logic [5:0] p);
    checks++;
    if (ifc.floor !== f || ifc.dir !== d || ifc.moving !== m || ifc.door_open !== o ||
        ifc.arrive !== a || ifc.pending !== p) begin
      failures++;
      $display("FAIL %s: got floor=%0d dir=%b moving=%b door_open=%b arrive=%b pending=%b, expected floor=%0d dir=%b moving=%b door_open=%b arrive=%b pending=%b",
               name, ifc.floor, ifc.dir, ifc.moving, ifc.door_open, ifc.arrive, ifc.pending,
               f, d, m, o, a, p);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    ifc.call_req   = '0;
    ifc.door_close = 1'b0;

    //   call       cl  fl dir mv do ar pend
    // floor 3 from reset
    addv(6'b001000, 0, 0, 1, 0, 0, 0, 6'b001000);
    addv(6'b000000, 0, 0, 1, 1, 0, 0, 6'b001000);
    addv(6'b000000, 0, 0, 1, 1, 0, 0, 6'b001000);
    addv(6'b000000, 0, 1, 1, 1, 0, 0, 6'b001000);
    addv(6'b000000, 0, 1, 1, 1, 0, 0, 6'b001000);
    addv(6'b000000, 0, 2, 1, 1, 0, 0, 6'b001000);
    addv(6'b000000, 0, 2, 1, 1, 0, 0, 6'b001000);
    addv(6'b000000, 0, 3, 1, 0, 1, 1, 6'b000000);
    addv(6'b000000, 0, 3, 1, 0, 1, 0, 6'b000000);
    addv(6'b000000, 0, 3, 1, 0, 1, 0, 6'b000000);
    addv(6'b000000, 0, 3, 1, 0, 0, 0, 6'b000000);
    addv(6'b000000, 1, 3, 1, 0, 0, 0, 6'b000000);
    // at 3 going up, pending 5 and 1: serve 5 then 1
    addv(6'b100010, 0, 3, 1, 0, 0, 0, 6'b100010);
    addv(6'b000000, 0, 3, 1, 1, 0, 0, 6'b100010);
    addv(6'b000000, 0, 3, 1, 1, 0, 0, 6'b100010);
    addv(6'b000000, 0, 4, 1, 1, 0, 0, 6'b100010);
    addv(6'b000000, 0, 4, 1, 1, 0, 0, 6'b100010);
    addv(6'b000000, 0, 5, 1, 0, 1, 1, 6'b000010);
    addv(6'b000000, 0, 5, 1, 0, 1, 0, 6'b000010);
    addv(6'b000000, 0, 5, 1, 0, 1, 0, 6'b000010);
    addv(6'b000000, 0, 5, 1, 0, 0, 0, 6'b000010);
    addv(6'b000000, 0, 5, 0, 1, 0, 0, 6'b000010);
    addv(6'b000000, 1, 5, 0, 1, 0, 0, 6'b000010);
    addv(6'b000000, 0, 4, 0, 1, 0, 0, 6'b000010);
    addv(6'b000000, 0, 4, 0, 1, 0, 0, 6'b000010);
    addv(6'b000000, 0, 3, 0, 1, 0, 0, 6'b000010);
    addv(6'b000000, 0, 3, 0, 1, 0, 0, 6'b000010);
    addv(6'b000000, 0, 2, 0, 1, 0, 0, 6'b000010);
    addv(6'b000000, 0, 2, 0, 1, 0, 0, 6'b000010);
    addv(6'b000000, 0, 1, 0, 0, 1, 1, 6'b000000);
    addv(6'b000000, 0, 1, 0, 0, 1, 0, 6'b000000);
    addv(6'b000000, 0, 1, 0, 0, 1, 0, 6'b000000);
    addv(6'b000000, 0, 1, 0, 0, 0, 0, 6'b000000);
    // early close on first DOOR cycle
    addv(6'b000010, 0, 1, 0, 0, 1, 1, 6'b000000);
    addv(6'b000000, 1, 1, 0, 0, 1, 0, 6'b000000);
    addv(6'b000000, 0, 1, 0, 0, 0, 0, 6'b000000);
    addv(6'b000000, 0, 1, 0, 0, 0, 0, 6'b000000);
    // close coinciding with same-floor call: call wins
    addv(6'b000010, 0, 1, 0, 0, 1, 1, 6'b000000);
    addv(6'b000010, 1, 1, 0, 0, 1, 0, 6'b000000);
    addv(6'b000000, 0, 1, 0, 0, 1, 0, 6'b000000);
    addv(6'b000000, 0, 1, 0, 0, 1, 0, 6'b000000);
    addv(6'b000000, 0, 1, 0, 0, 0, 0, 6'b000000);
    // down to 0, then same-floor call at 0
    addv(6'b000001, 0, 1, 0, 0, 0, 0, 6'b000001);
    addv(6'b000000, 0, 1, 0, 1, 0, 0, 6'b000001);
    addv(6'b000000, 0, 1, 0, 1, 0, 0, 6'b000001);
    addv(6'b000000, 0, 0, 0, 0, 1, 1, 6'b000000);
    addv(6'b000000, 0, 0, 0, 0, 1, 0, 6'b000000);
    addv(6'b000000, 0, 0, 0, 0, 1, 0, 6'b000000);
    addv(6'b000000, 0, 0, 0, 0, 0, 0, 6'b000000);
    addv(6'b000001, 0, 0, 0, 0, 1, 1, 6'b000000);
    addv(6'b000000, 0, 0, 0, 0, 1, 0, 6'b000000);
    addv(6'b000000, 0, 0, 0, 0, 1, 0, 6'b000000);
    addv(6'b000000, 0, 0, 0, 0, 0, 0, 6'b000000);
    // go to 2 (direction flips to up)
    addv(6'b000100, 0, 0, 0, 0, 0, 0, 6'b000100);
    addv(6'b000000, 0, 0, 1, 1, 0, 0, 6'b000100);
    addv(6'b000000, 0, 0, 1, 1, 0, 0, 6'b000100);
    addv(6'b000000, 0, 1, 1, 1, 0, 0, 6'b000100);
    addv(6'b000000, 0, 1, 1, 1, 0, 0, 6'b000100);
    addv(6'b000000, 0, 2, 1, 0, 1, 1, 6'b000000);
    addv(6'b000000, 0, 2, 1, 0, 1, 0, 6'b000000);
    addv(6'b000000, 0, 2, 1, 0, 1, 0, 6'b000000);
    addv(6'b000000, 0, 2, 1, 0, 0, 0, 6'b000000);
    // 2 -> 4 with call_req[2] while leaving 2, then reverse to 2
    addv(6'b010000, 0, 2, 1, 0, 0, 0, 6'b010000);
    addv(6'b000000, 0, 2, 1, 1, 0, 0, 6'b010000);
    addv(6'b000100, 0, 2, 1, 1, 0, 0, 6'b010100);
    addv(6'b000000, 0, 3, 1, 1, 0, 0, 6'b010100);
    addv(6'b000000, 0, 3, 1, 1, 0, 0, 6'b010100);
    addv(6'b000000, 0, 4, 1, 0, 1, 1, 6'b000100);
    addv(6'b000000, 0, 4, 1, 0, 1, 0, 6'b000100);
    addv(6'b000000, 0, 4, 1, 0, 1, 0, 6'b000100);
    addv(6'b000000, 0, 4, 1, 0, 0, 0, 6'b000100);
    addv(6'b000000, 0, 4, 0, 1, 0, 0, 6'b000100);
    addv(6'b000000, 0, 4, 0, 1, 0, 0, 6'b000100);
    addv(6'b000000, 0, 3, 0, 1, 0, 0, 6'b000100);
    addv(6'b000000, 0, 3, 0, 1, 0, 0, 6'b000100);
    addv(6'b000000, 0, 2, 0, 0, 1, 1, 6'b000000);
    addv(6'b000000, 0, 2, 0, 0, 1, 0, 6'b000000);
    addv(6'b000000, 0, 2, 0, 0, 1, 0, 6'b000000);
    addv(6'b000000, 0, 2, 0, 0, 0, 0, 6'b000000);
    // climb past 4 with three requests outstanding
    addv(6'b100000, 0, 2, 0, 0, 0, 0, 6'b100000);
    addv(6'b000000, 0, 2, 1, 1, 0, 0, 6'b100000);
    addv(6'b000110, 0, 2, 1, 1, 0, 0, 6'b100110);
    addv(6'b000000, 0, 3, 1, 1, 0, 0, 6'b100110);
    addv(6'b000000, 0, 3, 1, 1, 0, 0, 6'b100110);
    addv(6'b000000, 0, 4, 1, 1, 0, 0, 6'b100110);

    #1;
    check("reset_state", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 6'b000000);
    #1 reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      ifc.call_req   = vecs[i].call;
      ifc.door_close = vecs[i].close;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), vecs[i].floor, vecs[i].dir, vecs[i].moving,
            vecs[i].door_open, vecs[i].arrive, vecs[i].pend);
    end

    // Mid-move reset at floor 4: must clear without waiting for a clock edge.
    ifc.call_req   = '0;
    ifc.door_close = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("async_reset", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 6'b000000);
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    check("post_reset_idle", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 6'b000000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
